// File: rtl/instruction_fetcher_pkg.sv
// Shared constants and state encoding for the instruction fetcher.
package instruction_fetcher_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // state | meaning
    // FETCH | look up pc in the cache, hand hits to decode
    // MISS  | word read outstanding at the memory controller
    // FILL  | write the returned word into the cache line
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_MISS  = 2'd1,
        ST_FILL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetcher.sv
// Instruction fetch front end: cache lookup, miss handling through the memory
// controller, cache refill and a single-entry output register towards decode.
//
// state | meaning
// FETCH | look up pc; hit -> output slot, miss -> start memory read
// MISS  | memReq held until memDone; redirects are parked in pendFlush/pendPc
// FILL  | one-cycle cache write at missPc; word forwarded unless redirected
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic              rdyIn,
    output logic [WORD_W-1:0] pcOut,
    input  logic              cacheHit,
    input  logic [WORD_W-1:0] cacheData,
    output logic              cacheWrEn,
    output logic [WORD_W-1:0] cacheWrData,
    output logic              memReq,
    output logic [WORD_W-1:0] memAddr,
    input  logic              memDone,
    input  logic [WORD_W-1:0] memData,
    output logic              instValid,
    output logic [WORD_W-1:0] instOut,
    output logic [WORD_W-1:0] instPc,
    input  logic              instReady,
    input  logic              flushIn,
    input  logic [WORD_W-1:0] flushPc
);

    localparam logic [WORD_W-1:0] WORD_MASK    = ~32'h0000_0003;
    localparam logic [WORD_W-1:0] RESET_PC_ALN = RESET_PC & WORD_MASK;

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] miss_pc_q, miss_pc_d;
    logic              pend_flush_q, pend_flush_d;
    logic [WORD_W-1:0] pend_pc_q, pend_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [WORD_W-1:0] inst_out_q, inst_out_d;
    logic [WORD_W-1:0] inst_pc_q, inst_pc_d;
    logic              mem_req_q, mem_req_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] cache_wr_data_q, cache_wr_data_d;

    logic [WORD_W-1:0] flush_pc_w;
    logic              slot_free;

    assign flush_pc_w = flushPc & WORD_MASK;
    assign slot_free  = !inst_valid_q || instReady;

    // Cache index follows missPc while the refill is being written.
    assign pcOut       = (state_q == ST_FILL) ? miss_pc_q : pc_q;
    assign cacheWrEn   = (state_q == ST_FILL) && rdyIn && !rstIn;
    assign cacheWrData = cache_wr_data_q;
    assign memReq      = mem_req_q;
    assign memAddr     = mem_addr_q;
    assign instValid   = inst_valid_q;
    assign instOut     = inst_out_q;
    assign instPc      = inst_pc_q;

    // Next-state and register updates; rdyIn low leaves every register as is.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        miss_pc_d       = miss_pc_q;
        pend_flush_d    = pend_flush_q;
        pend_pc_d       = pend_pc_q;
        inst_valid_d    = inst_valid_q;
        inst_out_d      = inst_out_q;
        inst_pc_d       = inst_pc_q;
        mem_req_d       = mem_req_q;
        mem_addr_d      = mem_addr_q;
        cache_wr_data_d = cache_wr_data_q;

        if (rdyIn) begin
            if (inst_valid_q && instReady) begin
                inst_valid_d = 1'b0;
            end

            case (state_q)
                ST_FETCH: begin
                    if (flushIn) begin
                        inst_valid_d = 1'b0;
                        pc_d         = flush_pc_w;
                    end else if (cacheHit) begin
                        if (slot_free) begin
                            inst_valid_d = 1'b1;
                            inst_out_d   = cacheData;
                            inst_pc_d    = pc_q;
                            pc_d         = pc_q + 32'd4;
                        end
                    end else begin
                        miss_pc_d  = pc_q;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = ST_MISS;
                    end
                end

                ST_MISS: begin
                    // The read is never aborted; a redirect waits for the fill.
                    if (flushIn) begin
                        inst_valid_d = 1'b0;
                        pend_flush_d = 1'b1;
                        pend_pc_d    = flush_pc_w;
                    end
                    if (memDone) begin
                        cache_wr_data_d = memData;
                        mem_req_d       = 1'b0;
                        state_d         = ST_FILL;
                    end
                end

                ST_FILL: begin
                    state_d      = ST_FETCH;
                    pend_flush_d = 1'b0;
                    if (flushIn) begin
                        inst_valid_d = 1'b0;
                        pc_d         = flush_pc_w;
                    end else if (pend_flush_q) begin
                        pc_d = pend_pc_q;
                    end else if (slot_free) begin
                        // Forward the refilled word directly to save a lookup.
                        inst_valid_d = 1'b1;
                        inst_out_d   = cache_wr_data_q;
                        inst_pc_d    = miss_pc_q;
                        pc_d         = miss_pc_q + 32'd4;
                    end else begin
                        // Slot busy: refetch from the now-filled line later.
                        pc_d = miss_pc_q;
                    end
                end

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // State register with synchronous reset that overrides rdyIn.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q         <= ST_FETCH;
            pc_q            <= RESET_PC_ALN;
            miss_pc_q       <= '0;
            pend_flush_q    <= 1'b0;
            pend_pc_q       <= '0;
            inst_valid_q    <= 1'b0;
            inst_out_q      <= '0;
            inst_pc_q       <= '0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            cache_wr_data_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            miss_pc_q       <= miss_pc_d;
            pend_flush_q    <= pend_flush_d;
            pend_pc_q       <= pend_pc_d;
            inst_valid_q    <= inst_valid_d;
            inst_out_q      <= inst_out_d;
            inst_pc_q       <= inst_pc_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            cache_wr_data_q <= cache_wr_data_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a tiny combinational cache model.
module tb_instruction_fetcher;

    localparam logic [31:0] KEY = 32'h1357_0000;

    logic        clkIn;
    logic        rstIn;
    logic        rdyIn;
    logic [31:0] pcOut;
    logic        cacheHit;
    logic [31:0] cacheData;
    logic        cacheWrEn;
    logic [31:0] cacheWrData;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memDone;
    logic [31:0] memData;
    logic        instValid;
    logic [31:0] instOut;
    logic [31:0] instPc;
    logic        instReady;
    logic        flushIn;
    logic [31:0] flushPc;

    logic        miss_on;
    logic [31:0] miss_addr;

    int n_cmp;
    int n_err;

    instruction_fetcher dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .rdyIn       (rdyIn),
        .pcOut       (pcOut),
        .cacheHit    (cacheHit),
        .cacheData   (cacheData),
        .cacheWrEn   (cacheWrEn),
        .cacheWrData (cacheWrData),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memDone     (memDone),
        .memData     (memData),
        .instValid   (instValid),
        .instOut     (instOut),
        .instPc      (instPc),
        .instReady   (instReady),
        .flushIn     (flushIn),
        .flushPc     (flushPc)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    // Cache model: every address hits with pc^KEY except one armed miss address.
    always_comb begin
        cacheHit  = !(miss_on && (pcOut == miss_addr));
        cacheData = pcOut ^ KEY;
    end

    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic test_reset();
        rstIn = 1'b1;
        step();
        step();
        n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL reset_instValid got %h want %h", instValid, 1'b0); end
        n_cmp++; if (instPc !== 32'h0) begin n_err++; $display("FAIL reset_instPc got %h want %h", instPc, 32'h0); end
        n_cmp++; if (instOut !== 32'h0) begin n_err++; $display("FAIL reset_instOut got %h want %h", instOut, 32'h0); end
        n_cmp++; if (memReq !== 1'b0) begin n_err++; $display("FAIL reset_memReq got %h want %h", memReq, 1'b0); end
        n_cmp++; if (memAddr !== 32'h0) begin n_err++; $display("FAIL reset_memAddr got %h want %h", memAddr, 32'h0); end
        n_cmp++; if (cacheWrEn !== 1'b0) begin n_err++; $display("FAIL reset_cacheWrEn got %h want %h", cacheWrEn, 1'b0); end
        n_cmp++; if (cacheWrData !== 32'h0) begin n_err++; $display("FAIL reset_cacheWrData got %h want %h", cacheWrData, 32'h0); end
        n_cmp++; if (pcOut !== 32'h0) begin n_err++; $display("FAIL reset_pcOut got %h want %h", pcOut, 32'h0); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        rstIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            step();
            n_cmp++; if (instValid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %h want %h", i, instValid, 1'b1); end
            n_cmp++; if (instPc !== exp_pc) begin n_err++; $display("FAIL stream_instPc[%0d] got %h want %h", i, instPc, exp_pc); end
            n_cmp++; if (instOut !== (exp_pc ^ KEY)) begin n_err++; $display("FAIL stream_instOut[%0d] got %h want %h", i, instOut, exp_pc ^ KEY); end
        end
    endtask

    task automatic test_stall();
        instReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (instPc !== 32'd12) begin n_err++; $display("FAIL stall_instPc[%0d] got %h want %h", i, instPc, 32'd12); end
            n_cmp++; if (instOut !== (32'd12 ^ KEY)) begin n_err++; $display("FAIL stall_instOut[%0d] got %h want %h", i, instOut, 32'd12 ^ KEY); end
            n_cmp++; if (pcOut !== 32'd16) begin n_err++; $display("FAIL stall_pcOut[%0d] got %h want %h", i, pcOut, 32'd16); end
        end
        instReady = 1'b1;
        step();
        n_cmp++; if (instPc !== 32'd16 || instValid !== 1'b1) begin n_err++; $display("FAIL stall_resume got pc %h v %h want pc %h v 1", instPc, instValid, 32'd16); end
    endtask

    task automatic test_memdone_ignored();
        memDone = 1'b1;
        memData = 32'hBAD0_0001;
        step();
        memDone = 1'b0;
        n_cmp++; if (cacheWrData !== 32'h0) begin n_err++; $display("FAIL stray_done_wrdata got %h want %h", cacheWrData, 32'h0); end
        n_cmp++; if (instPc !== 32'd20 || memReq !== 1'b0) begin n_err++; $display("FAIL stray_done_flow got pc %h req %h want pc %h req 0", instPc, memReq, 32'd20); end
    endtask

    task automatic test_miss();
        flushIn = 1'b1; flushPc = 32'h100; miss_addr = 32'h100; miss_on = 1'b1;
        step();
        flushIn = 1'b0;
        n_cmp++; if (instValid !== 1'b0 || pcOut !== 32'h100) begin n_err++; $display("FAIL miss_redirect got v %h pc %h want v 0 pc %h", instValid, pcOut, 32'h100); end
        step();
        n_cmp++; if (memReq !== 1'b1 || memAddr !== 32'h100) begin n_err++; $display("FAIL miss_req got req %h addr %h want req 1 addr %h", memReq, memAddr, 32'h100); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (memReq !== 1'b1 || cacheWrEn !== 1'b0) begin n_err++; $display("FAIL miss_hold[%0d] got req %h we %h want req 1 we 0", i, memReq, cacheWrEn); end
        end
        memDone = 1'b1; memData = 32'h0050_0093;
        step();
        memDone = 1'b0;
        n_cmp++; if (cacheWrEn !== 1'b1) begin n_err++; $display("FAIL fill_we got %h want %h", cacheWrEn, 1'b1); end
        n_cmp++; if (pcOut !== 32'h100) begin n_err++; $display("FAIL fill_pcOut got %h want %h", pcOut, 32'h100); end
        n_cmp++; if (cacheWrData !== 32'h0050_0093) begin n_err++; $display("FAIL fill_wrdata got %h want %h", cacheWrData, 32'h0050_0093); end
        n_cmp++; if (memReq !== 1'b0 || instValid !== 1'b0) begin n_err++; $display("FAIL fill_req got req %h v %h want req 0 v 0", memReq, instValid); end
        miss_on = 1'b0;
        step();
        n_cmp++; if (instValid !== 1'b1 || instPc !== 32'h100) begin n_err++; $display("FAIL miss_valid got v %h pc %h want v 1 pc %h", instValid, instPc, 32'h100); end
        n_cmp++; if (instOut !== 32'h0050_0093) begin n_err++; $display("FAIL miss_instOut got %h want %h", instOut, 32'h0050_0093); end
        n_cmp++; if (cacheWrEn !== 1'b0 || pcOut !== 32'h104) begin n_err++; $display("FAIL after_fill got we %h pc %h want we 0 pc %h", cacheWrEn, pcOut, 32'h104); end
        step();
        n_cmp++; if (instPc !== 32'h104 || instOut !== (32'h104 ^ KEY)) begin n_err++; $display("FAIL after_miss_next got pc %h d %h want pc %h d %h", instPc, instOut, 32'h104, 32'h104 ^ KEY); end
    endtask

    task automatic test_flush_miss();
        flushIn = 1'b1; flushPc = 32'h40; miss_addr = 32'h40; miss_on = 1'b1;
        step();
        flushIn = 1'b0;
        step();
        n_cmp++; if (memReq !== 1'b1 || memAddr !== 32'h40) begin n_err++; $display("FAIL fmiss_req got req %h addr %h want req 1 addr %h", memReq, memAddr, 32'h40); end
        flushIn = 1'b1; flushPc = 32'h300;
        step();
        n_cmp++; if (memReq !== 1'b1 || instValid !== 1'b0) begin n_err++; $display("FAIL fmiss_no_abort got req %h v %h want req 1 v 0", memReq, instValid); end
        flushPc = 32'h200;
        step();
        flushIn = 1'b0;
        step();
        n_cmp++; if (memReq !== 1'b1) begin n_err++; $display("FAIL fmiss_hold got %h want %h", memReq, 1'b1); end
        memDone = 1'b1; memData = 32'hCAFE_0040;
        step();
        memDone = 1'b0;
        n_cmp++; if (cacheWrEn !== 1'b1 || pcOut !== 32'h40 || cacheWrData !== 32'hCAFE_0040) begin n_err++; $display("FAIL fmiss_fill got we %h pc %h d %h want we 1 pc %h d %h", cacheWrEn, pcOut, cacheWrData, 32'h40, 32'hCAFE_0040); end
        miss_on = 1'b0;
        step();
        n_cmp++; if (instValid !== 1'b0 || pcOut !== 32'h200) begin n_err++; $display("FAIL fmiss_redirect got v %h pc %h want v 0 pc %h", instValid, pcOut, 32'h200); end
        step();
        n_cmp++; if (instValid !== 1'b1 || instPc !== 32'h200 || instOut !== (32'h200 ^ KEY)) begin n_err++; $display("FAIL fmiss_next got v %h pc %h d %h want v 1 pc %h d %h", instValid, instPc, instOut, 32'h200, 32'h200 ^ KEY); end
    endtask

    task automatic test_wrap_flush();
        flushIn = 1'b1; flushPc = 32'hFFFF_FFFC;
        step();
        flushIn = 1'b0;
        n_cmp++; if (instValid !== 1'b0 || pcOut !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_redirect got v %h pc %h want v 0 pc %h", instValid, pcOut, 32'hFFFF_FFFC); end
        step();
        n_cmp++; if (instPc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_last got %h want %h", instPc, 32'hFFFF_FFFC); end
        step();
        n_cmp++; if (instPc !== 32'h0 || pcOut !== 32'h4) begin n_err++; $display("FAIL wrap_zero got pc %h next %h want pc 0 next 4", instPc, pcOut); end
        flushIn = 1'b1; flushPc = 32'h83;
        step();
        flushIn = 1'b0;
        n_cmp++; if (instValid !== 1'b0 || pcOut !== 32'h80) begin n_err++; $display("FAIL flush_ready got v %h pc %h want v 0 pc %h", instValid, pcOut, 32'h80); end
        step();
        n_cmp++; if (instValid !== 1'b1 || instPc !== 32'h80) begin n_err++; $display("FAIL flush_next got v %h pc %h want v 1 pc %h", instValid, instPc, 32'h80); end
    endtask

    task automatic test_rdy();
        rdyIn = 1'b0;
        step();
        step();
        n_cmp++; if (instPc !== 32'h80 || pcOut !== 32'h84) begin n_err++; $display("FAIL rdy_freeze got pc %h next %h want pc %h next %h", instPc, pcOut, 32'h80, 32'h84); end
        rdyIn = 1'b1;
        flushIn = 1'b1; flushPc = 32'h500; miss_addr = 32'h500; miss_on = 1'b1;
        step();
        flushIn = 1'b0;
        step();
        rdyIn = 1'b0;
        step();
        n_cmp++; if (memReq !== 1'b1 || memAddr !== 32'h500) begin n_err++; $display("FAIL rdy_req_hold got req %h addr %h want req 1 addr %h", memReq, memAddr, 32'h500); end
        rdyIn = 1'b1; memDone = 1'b1; memData = 32'h1111_2222;
        step();
        memDone = 1'b0;
        rdyIn = 1'b0;
        #1;
        n_cmp++; if (cacheWrEn !== 1'b0) begin n_err++; $display("FAIL rdy_we_forced got %h want %h", cacheWrEn, 1'b0); end
        step();
        n_cmp++; if (cacheWrEn !== 1'b0 || pcOut !== 32'h500) begin n_err++; $display("FAIL rdy_fill_hold got we %h pc %h want we 0 pc %h", cacheWrEn, pcOut, 32'h500); end
        rdyIn = 1'b1; miss_on = 1'b0;
        #1;
        n_cmp++; if (cacheWrEn !== 1'b1) begin n_err++; $display("FAIL rdy_we_resume got %h want %h", cacheWrEn, 1'b1); end
        step();
        n_cmp++; if (instValid !== 1'b1 || instPc !== 32'h500 || instOut !== 32'h1111_2222) begin n_err++; $display("FAIL rdy_fill_out got v %h pc %h d %h want v 1 pc %h d %h", instValid, instPc, instOut, 32'h500, 32'h1111_2222); end
    endtask

    task automatic test_reset_mid_miss();
        flushIn = 1'b1; flushPc = 32'h600; miss_addr = 32'h600; miss_on = 1'b1;
        step();
        flushIn = 1'b0;
        step();
        n_cmp++; if (memReq !== 1'b1) begin n_err++; $display("FAIL rmiss_req got %h want %h", memReq, 1'b1); end
        rstIn = 1'b1; rdyIn = 1'b0;
        step();
        n_cmp++; if (memReq !== 1'b0 || memAddr !== 32'h0 || pcOut !== 32'h0) begin n_err++; $display("FAIL rmiss_reset got req %h addr %h pc %h want 0 0 0", memReq, memAddr, pcOut); end
        n_cmp++; if (instValid !== 1'b0 || cacheWrData !== 32'h0 || cacheWrEn !== 1'b0) begin n_err++; $display("FAIL rmiss_regs got v %h d %h we %h want 0 0 0", instValid, cacheWrData, cacheWrEn); end
        rstIn = 1'b0; rdyIn = 1'b1; miss_on = 1'b0;
        step();
        n_cmp++; if (instValid !== 1'b1 || instPc !== 32'h0) begin n_err++; $display("FAIL rmiss_restart got v %h pc %h want v 1 pc 0", instValid, instPc); end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rstIn     = 1'b1;
        rdyIn     = 1'b1;
        instReady = 1'b1;
        memDone   = 1'b0;
        memData   = 32'h0;
        flushIn   = 1'b0;
        flushPc   = 32'h0;
        miss_on   = 1'b0;
        miss_addr = 32'h0;

        test_reset();
        test_stream();
        test_stall();
        test_memdone_ignored();
        test_miss();
        test_flush_miss();
        test_wrap_flush();
        test_rdy();
        test_reset_mid_miss();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
